// File: rtl/neuron_pkg.sv
// Shared types and constants for the time-multiplexed threshold-neuron layer.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL0 = 2'd1,
        MUL1 = 2'd2,
        CMP  = 2'd3
    } state_t;

    localparam logic [1:0] CFG_W0     = 2'd0;
    localparam logic [1:0] CFG_W1     = 2'd1;
    localparam logic [1:0] CFG_BIAS   = 2'd2;
    localparam logic [1:0] CFG_THRESH = 2'd3;

    localparam int DEF_NUM_NEURONS = 4;
    localparam int DEF_XW          = 4;
    localparam int DEF_WW          = 4;
    localparam int DEF_ACCW        = 10;

endpackage

// File: rtl/neuron_layer_sched_if.sv
// Start/config/result bus of the neuron layer scheduler.
interface neuron_layer_sched_if #(
    parameter int NUM_NEURONS = 4,
    parameter int XW          = 4,
    parameter int ACCW        = 10
);
    localparam int AW = $clog2(NUM_NEURONS);

    logic                   start;
    logic [XW-1:0]          x0;
    logic [XW-1:0]          x1;
    logic                   cfg_we;
    logic [AW-1:0]          cfg_addr;
    logic [1:0]             cfg_sel;
    logic [ACCW-1:0]        cfg_data;
    logic                   busy;
    logic                   out_valid;
    logic [NUM_NEURONS-1:0] y_out;
    logic                   cfg_err;

    modport master (
        output start, x0, x1, cfg_we, cfg_addr, cfg_sel, cfg_data,
        input  busy, out_valid, y_out, cfg_err
    );

    modport slave (
        input  start, x0, x1, cfg_we, cfg_addr, cfg_sel, cfg_data,
        output busy, out_valid, y_out, cfg_err
    );

endinterface

// File: rtl/neuron_mac.sv
// Shared combinational multiply-add: sum = addend + w*x (unsigned).
module neuron_mac #(
    parameter int XW   = 4,
    parameter int WW   = 4,
    parameter int ACCW = 10
) (
    input  logic [WW-1:0]   w,
    input  logic [XW-1:0]   x,
    input  logic [ACCW-1:0] addend,
    output logic [ACCW-1:0] sum
);
    logic [WW+XW-1:0] prod;

    always_comb begin
        prod = {{XW{1'b0}}, w} * {{WW{1'b0}}, x};
        sum  = addend + {{(ACCW-WW-XW){1'b0}}, prod};
    end

endmodule

// File: rtl/neuron_layer_sched.sv
// Evaluates NUM_NEURONS threshold neurons through one shared MAC, three cycles
// per neuron, with a runtime-writable per-neuron config register file.
module neuron_layer_sched
    import neuron_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int XW          = DEF_XW,
    parameter int WW          = DEF_WW,
    parameter int ACCW        = DEF_ACCW
) (
    input logic               clk,
    input logic               rst_n,
    neuron_layer_sched_if.slave bus
);
    localparam int AW = $clog2(NUM_NEURONS);

    state_t                 state;
    logic [AW-1:0]          idx;
    logic [XW-1:0]          x0_q, x1_q;
    logic [ACCW-1:0]        acc;
    logic [NUM_NEURONS-1:0] y_next, y_final, y_q;
    logic                   busy_q, valid_q, err_q;

    logic [WW-1:0]          w0_r   [NUM_NEURONS];
    logic [WW-1:0]          w1_r   [NUM_NEURONS];
    logic [WW-1:0]          bias_r [NUM_NEURONS];
    logic [ACCW-1:0]        th_r   [NUM_NEURONS];

    logic                   cfg_ok, last, fire;
    logic [WW-1:0]          mac_w;
    logic [XW-1:0]          mac_x;
    logic [ACCW-1:0]        mac_add, mac_sum;

    always_comb begin
        cfg_ok  = bus.cfg_we && (state == IDLE) &&
                  (32'(bus.cfg_addr) < 32'(NUM_NEURONS));
        last    = (32'(idx) == 32'(NUM_NEURONS - 1));
        fire    = (acc >= th_r[idx]);
        y_final = y_next;
        y_final[idx] = fire;
        // MUL0 seeds the sum with the bias, MUL1 accumulates onto acc.
        if (state == MUL0) begin
            mac_w   = w0_r[idx];
            mac_x   = x0_q;
            mac_add = {{(ACCW-WW){1'b0}}, bias_r[idx]};
        end else begin
            mac_w   = w1_r[idx];
            mac_x   = x1_q;
            mac_add = acc;
        end
    end

    neuron_mac #(.XW(XW), .WW(WW), .ACCW(ACCW)) u_mac (
        .w      (mac_w),
        .x      (mac_x),
        .addend (mac_add),
        .sum    (mac_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                w0_r[i]   <= '0;
                w1_r[i]   <= '0;
                bias_r[i] <= '0;
                th_r[i]   <= '1;
            end
            err_q <= 1'b0;
        end else begin
            err_q <= bus.cfg_we && !cfg_ok;
            if (cfg_ok) begin
                case (bus.cfg_sel)
                    CFG_W0:   w0_r[bus.cfg_addr]   <= bus.cfg_data[WW-1:0];
                    CFG_W1:   w1_r[bus.cfg_addr]   <= bus.cfg_data[WW-1:0];
                    CFG_BIAS: bias_r[bus.cfg_addr] <= bus.cfg_data[WW-1:0];
                    default:  th_r[bus.cfg_addr]   <= bus.cfg_data;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            acc     <= '0;
            y_next  <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x0_q   <= bus.x0;
                        x1_q   <= bus.x1;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= MUL0;
                    end
                end
                MUL0: begin
                    acc   <= mac_sum;
                    state <= MUL1;
                end
                MUL1: begin
                    acc   <= mac_sum;
                    state <= CMP;
                end
                default: begin
                    y_next[idx] <= fire;
                    if (!last) begin
                        idx   <= idx + 1'b1;
                        state <= MUL0;
                    end else begin
                        y_q     <= y_final;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = valid_q;
    assign bus.y_out     = y_q;
    assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Directed bench for neuron_layer_sched with a queue scoreboard of expected fire vectors.
module tb_neuron_layer_sched;
    import neuron_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    neuron_layer_sched_if #(.NUM_NEURONS(N), .XW(4), .ACCW(10)) bus ();

    neuron_layer_sched #(.NUM_NEURONS(N), .XW(4), .WW(4), .ACCW(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int pass_edges = 0;
    logic [N-1:0] exp_q[$];
    int unsigned m_w0[N], m_w1[N], m_bias[N], m_th[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_w0[i] = 0; m_w1[i] = 0; m_bias[i] = 0; m_th[i] = 1023;
        end
    endtask

    function automatic logic [N-1:0] model_y(input int unsigned x0, input int unsigned x1);
        logic [N-1:0] y;
        for (int i = 0; i < N; i++)
            y[i] = (m_bias[i] + m_w0[i] * x0 + m_w1[i] * x1) >= m_th[i];
        return y;
    endfunction

    // All tasks begin and end at a falling edge.
    task automatic wait_edges(input int n);
        repeat (n) begin
            @(negedge clk);
            pass_edges++;
        end
    endtask

    task automatic cfg_write(input int a, input logic [1:0] sel, input int unsigned d);
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'(a); bus.cfg_sel = sel; bus.cfg_data = 10'(d);
        @(negedge clk);
        bus.cfg_we = 1'b0;
        case (sel)
            CFG_W0:   m_w0[a]   = d & 15;
            CFG_W1:   m_w1[a]   = d & 15;
            CFG_BIAS: m_bias[a] = d & 15;
            default:  m_th[a]   = d & 1023;
        endcase
        chk("cfg_err_idle_write", 32'(bus.cfg_err), 32'(0));
    endtask

    task automatic start_pass(input int unsigned x0, input int unsigned x1);
        bus.start = 1'b1; bus.x0 = 4'(x0); bus.x1 = 4'(x1);
        exp_q.push_back(model_y(x0, x1));
        @(negedge clk);
        bus.start = 1'b0;
        pass_edges = 0;
    endtask

    task automatic wait_done(input string tag);
        logic [N-1:0] e;
        while (bus.out_valid !== 1'b1 && pass_edges < 40) begin
            @(negedge clk);
            pass_edges++;
            if (bus.out_valid !== 1'b1)
                chk({tag, "_busy"}, 32'(bus.busy), 32'(1));
        end
        chk({tag, "_latency"}, 32'(pass_edges), 32'(12));
        chk({tag, "_busy_fall"}, 32'(bus.busy), 32'(0));
        if (exp_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'(1), 32'(0));
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_y_out"}, 32'(bus.y_out), 32'(e));
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.x0 = '0; bus.x1 = '0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_sel = '0; bus.cfg_data = '0;
        model_reset();
        #12;
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_y_out", 32'(bus.y_out), 32'(0));
        chk("rst_cfg_err", 32'(bus.cfg_err), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Unconfigured neurons never fire.
        start_pass(15, 15);
        wait_done("default_pass");
        @(negedge clk);

        // Neuron0 acc=8>=6 fires, neuron1 acc=8<10 does not.
        cfg_write(0, CFG_W0, 2);  cfg_write(0, CFG_W1, 1);
        cfg_write(0, CFG_BIAS, 1); cfg_write(0, CFG_THRESH, 6);
        cfg_write(1, CFG_W0, 1);  cfg_write(1, CFG_W1, 3);
        cfg_write(1, CFG_BIAS, 2); cfg_write(1, CFG_THRESH, 10);
        start_pass(3, 1);
        wait_done("basic_pass");
        chk("basic_y_literal", 32'(bus.y_out), 32'(4'b0001));
        @(negedge clk);

        // Inclusive threshold boundary at acc=465.
        cfg_write(0, CFG_W0, 15); cfg_write(0, CFG_W1, 15);
        cfg_write(0, CFG_BIAS, 15); cfg_write(0, CFG_THRESH, 465);
        start_pass(15, 15);
        wait_done("thresh_eq");
        chk("thresh_eq_bit0", 32'(bus.y_out[0]), 32'(1));
        @(negedge clk);
        cfg_write(0, CFG_THRESH, 466);
        start_pass(15, 15);
        wait_done("thresh_gt");
        chk("thresh_gt_bit0", 32'(bus.y_out[0]), 32'(0));
        @(negedge clk);

        // Busy rules: late start ignored, busy write rejected with one cfg_err pulse.
        start_pass(0, 0);
        wait_edges(4);
        bus.start = 1'b1; bus.x0 = 4'd15; bus.x1 = 4'd15;
        wait_edges(1);
        bus.start = 1'b0;
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_sel = CFG_THRESH; bus.cfg_data = 10'd0;
        chk("hold_y_mid_pass", 32'(bus.y_out), 32'(4'b0010));
        wait_edges(1);
        bus.cfg_we = 1'b0;
        chk("busy_cfg_err_pulse", 32'(bus.cfg_err), 32'(1));
        wait_edges(1);
        chk("busy_cfg_err_once", 32'(bus.cfg_err), 32'(0));
        wait_done("busy_pass");
        // Back-to-back start in the out_valid cycle.
        start_pass(15, 15);
        wait_done("b2b_pass");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_no_valid", 32'(bus.out_valid), 32'(0));
            chk("idle_no_busy", 32'(bus.busy), 32'(0));
        end

        // Async reset mid-pass clears state and config.
        cfg_write(0, CFG_THRESH, 1);
        start_pass(15, 15);
        wait_edges(6);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'(0));
        chk("mid_rst_y_out", 32'(bus.y_out), 32'(0));
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
        void'(exp_q.pop_front());
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'(0));
        start_pass(15, 15);
        wait_done("post_rst_pass");
        chk("post_rst_y_zero", 32'(bus.y_out), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
